// File: rtl/sequenciador_pilha_rpn_pkg.sv
// Shared types for the RPN calculator: sequencer states, error codes
// and the opcode set understood by the ALU.
package calc_rpn_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        DISPARA,
        ESPERA
    } estado_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2,
        ERR_ULA  = 2'd3
    } erro_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

endpackage

// File: rtl/sequenciador_pilha_rpn_if.sv
// Sequencer <-> ALU handshake: operands/opcode with a start strobe out,
// result/fault qualified by done back.
interface sequenciador_pilha_rpn_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] ula_a;
    logic [DATA_W-1:0] ula_b;
    logic [2:0]        ula_op;
    logic              ula_start;
    logic              ula_done;
    logic [DATA_W-1:0] ula_resultado;
    logic              ula_erro;

    modport master (
        output ula_a, ula_b, ula_op, ula_start,
        input  ula_done, ula_resultado, ula_erro
    );

    modport slave (
        input  ula_a, ula_b, ula_op, ula_start,
        output ula_done, ula_resultado, ula_erro
    );
endinterface

// File: rtl/sequenciador_pilha_rpn_pilha.sv
// Operand stack storage: push, atomic pop-two-push-one, clear.
// Exposes top/second (0 when absent) and current depth.
module pilha_registradores #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop2_push,
    input  logic                           clear,
    input  logic [DATA_W-1:0]              dado,
    output logic [DATA_W-1:0]              top,
    output logic [DATA_W-1:0]              second,
    output logic [$clog2(STACK_DEPTH):0]   depth
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]     cnt;
    logic [AW-1:0]     push_idx;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     sec_idx;
    logic              can_push;
    logic              can_pop2;

    assign push_idx = AW'(cnt);
    assign top_idx  = AW'(cnt - PW'(1));
    assign sec_idx  = AW'(cnt - PW'(2));
    assign can_push = (cnt < PW'(STACK_DEPTH));
    assign can_pop2 = (cnt >= PW'(2));

    // Entry storage; contents above the pointer are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push && can_push)
                mem[push_idx] <= dado;
            else if (pop2_push && can_pop2)
                mem[sec_idx] <= dado;
        end
    end

    // Stack pointer; saturates at both ends instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (push && can_push)
            cnt <= cnt + PW'(1);
        else if (pop2_push && can_pop2)
            cnt <= cnt - PW'(1);
    end

    // Gate reads so an empty or single-entry stack shows zeros.
    always_comb begin
        top    = '0;
        second = '0;
        if (cnt >= PW'(1))
            top = mem[top_idx];
        if (cnt >= PW'(2))
            second = mem[sec_idx];
    end

    assign depth = cnt;
endmodule

// File: rtl/sequenciador_pilha_rpn.sv
// RPN sequencer: stack commands from pulse inputs, ALU dispatch through a
// start/done handshake with a bounded wait, sticky error code.
module sequenciador_pilha_rpn
    import calc_rpn_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enter_pulso,
    input  logic                          executar_pulso,
    input  logic                          limpar_pulso,
    input  logic [DATA_W-1:0]             dados_entrada,
    input  logic [2:0]                    sel_op,
    sequenciador_pilha_rpn_if.master      ula,
    output logic [DATA_W-1:0]             topo,
    output logic [$clog2(STACK_DEPTH):0]  profundidade,
    output logic                          ocupado,
    output logic [1:0]                    erro
);
    localparam int PW = $clog2(STACK_DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    estado_t           estado, estado_prox;
    erro_t             erro_r, erro_prox;
    logic [CW-1:0]     tmo, tmo_prox;
    logic [DATA_W-1:0] a_r, b_r;
    logic [2:0]        op_r;
    logic              captura;
    logic              push, pop2_push, clear;
    logic [DATA_W-1:0] dado_pilha;
    logic [DATA_W-1:0] segundo;

    pilha_registradores #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_pilha (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop2_push (pop2_push),
        .clear     (clear),
        .dado      (dado_pilha),
        .top       (topo),
        .second    (segundo),
        .depth     (profundidade)
    );

    // State, error, wait counter and operand/opcode snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            erro_r <= ERR_NONE;
            tmo    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
        end else begin
            estado <= estado_prox;
            erro_r <= erro_prox;
            tmo    <= tmo_prox;
            if (captura) begin
                a_r  <= segundo;
                b_r  <= topo;
                op_r <= sel_op;
            end
        end
    end

    // Command decode and next state; limpar wins over everything, even mid-op.
    always_comb begin
        estado_prox = estado;
        erro_prox   = erro_r;
        tmo_prox    = tmo;
        captura     = 1'b0;
        push        = 1'b0;
        pop2_push   = 1'b0;
        clear       = 1'b0;
        dado_pilha  = dados_entrada;
        case (estado)
            OCIOSO: begin
                tmo_prox = '0;
                if (limpar_pulso) begin
                    clear     = 1'b1;
                    erro_prox = ERR_NONE;
                end else if (executar_pulso) begin
                    if (profundidade < PW'(2)) begin
                        erro_prox = ERR_UNF;
                    end else begin
                        captura     = 1'b1;
                        erro_prox   = ERR_NONE;
                        estado_prox = DISPARA;
                    end
                end else if (enter_pulso) begin
                    if (profundidade == PW'(STACK_DEPTH)) begin
                        erro_prox = ERR_OVF;
                    end else begin
                        push      = 1'b1;
                        erro_prox = ERR_NONE;
                    end
                end
            end
            DISPARA: begin
                tmo_prox = '0;
                if (limpar_pulso) begin
                    clear       = 1'b1;
                    erro_prox   = ERR_NONE;
                    estado_prox = OCIOSO;
                end else begin
                    estado_prox = ESPERA;
                end
            end
            ESPERA: begin
                if (limpar_pulso) begin
                    clear       = 1'b1;
                    erro_prox   = ERR_NONE;
                    estado_prox = OCIOSO;
                end else if (ula.ula_done) begin
                    if (ula.ula_erro) begin
                        erro_prox = ERR_ULA;
                    end else begin
                        pop2_push  = 1'b1;
                        dado_pilha = ula.ula_resultado;
                        erro_prox  = ERR_NONE;
                    end
                    estado_prox = OCIOSO;
                end else if (tmo == CW'(TIMEOUT - 1)) begin
                    erro_prox   = ERR_ULA;
                    estado_prox = OCIOSO;
                end else begin
                    tmo_prox = tmo + CW'(1);
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    assign ula.ula_a     = a_r;
    assign ula.ula_b     = b_r;
    assign ula.ula_op    = op_r;
    assign ula.ula_start = (estado == DISPARA);
    assign ocupado       = (estado != OCIOSO);
    assign erro          = erro_r;
endmodule

// File: tb/tb_sequenciador_pilha_rpn.sv
// Directed bench for the RPN sequencer: a command table with hand-computed
// stack contents, then hand-written timeout/abort/reset/priority sequences.
module tb_sequenciador_pilha_rpn;
    import calc_rpn_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enter_pulso = 1'b0;
    logic       executar_pulso = 1'b0;
    logic       limpar_pulso = 1'b0;
    logic [7:0] dados_entrada = '0;
    logic [2:0] sel_op = '0;
    logic [7:0] topo;
    logic [2:0] profundidade;
    logic       ocupado;
    logic [1:0] erro;

    int pass_cnt = 0;
    int total_cnt = 0;

    sequenciador_pilha_rpn_if #(.DATA_W(8)) ula_if ();

    sequenciador_pilha_rpn #(
        .DATA_W      (8),
        .STACK_DEPTH (4),
        .TIMEOUT     (15)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enter_pulso    (enter_pulso),
        .executar_pulso (executar_pulso),
        .limpar_pulso   (limpar_pulso),
        .dados_entrada  (dados_entrada),
        .sel_op         (sel_op),
        .ula            (ula_if.master),
        .topo           (topo),
        .profundidade   (profundidade),
        .ocupado        (ocupado),
        .erro           (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cmd;        // 0 enter, 1 executar, 2 limpar
        logic [7:0] dado;
        logic [2:0] op;
        int         mode;       // ALU: 0 answers, 1 answers with fault, 2 silent
        logic [7:0] res;
        int         exp_topo;
        int         exp_prof;
        int         exp_erro;
        int         exp_starts;
        int         exp_a;
        int         exp_b;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Called at a negedge with executar_pulso already driven; plays the ALU.
    task automatic run_exec(input int mode, input logic [7:0] res,
                            output int starts, output int cycles,
                            output int a_seen, output int b_seen, output int op_seen);
        bit fire;
        starts = 0; cycles = 0; a_seen = -1; b_seen = -1; op_seen = -1;
        fire = 1'b0;
        @(negedge clk);
        executar_pulso = 1'b0;
        enter_pulso    = 1'b0;
        limpar_pulso   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ula_if.ula_done = 1'b0;
            ula_if.ula_erro = 1'b0;
            if (!ocupado) break;
            if (fire && mode != 2) begin
                ula_if.ula_done      = 1'b1;
                ula_if.ula_erro      = (mode == 1);
                ula_if.ula_resultado = res;
            end
            fire = ula_if.ula_start;
            if (ula_if.ula_start) begin
                starts++;
                a_seen  = int'(ula_if.ula_a);
                b_seen  = int'(ula_if.ula_b);
                op_seen = int'(ula_if.ula_op);
            end
            cycles++;
            @(negedge clk);
        end
        ula_if.ula_done = 1'b0;
        ula_if.ula_erro = 1'b0;
    endtask

    task automatic pulse(input int cmd, input logic [7:0] d);
        if (cmd == 0) begin
            enter_pulso   = 1'b1;
            dados_entrada = d;
        end else begin
            limpar_pulso = 1'b1;
        end
        @(negedge clk);
        enter_pulso  = 1'b0;
        limpar_pulso = 1'b0;
    endtask

    initial begin
        int starts, cycles, a_seen, b_seen, op_seen;
        vec_t v;

        //           cmd dado  op     md res  topo prof err st  a  b
        vecs[0]  = '{0, 8'd5,  OP_ADD, 0, 8'd0,   5, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 8'd3,  OP_ADD, 0, 8'd0,   3, 2, 0, 0, 0, 0};
        vecs[2]  = '{1, 8'd0,  OP_ADD, 0, 8'd8,   8, 1, 0, 1, 5, 3};
        vecs[3]  = '{1, 8'd0,  OP_ADD, 0, 8'd0,   8, 1, 2, 0, 0, 0};
        vecs[4]  = '{0, 8'd7,  OP_ADD, 0, 8'd0,   7, 2, 0, 0, 0, 0};
        vecs[5]  = '{0, 8'd0,  OP_ADD, 0, 8'd0,   0, 3, 0, 0, 0, 0};
        vecs[6]  = '{1, 8'd0,  OP_DIV, 1, 8'd0,   0, 3, 3, 1, 7, 0};
        vecs[7]  = '{0, 8'd9,  OP_ADD, 0, 8'd0,   9, 4, 0, 0, 0, 0};
        vecs[8]  = '{0, 8'd11, OP_ADD, 0, 8'd0,   9, 4, 1, 0, 0, 0};
        vecs[9]  = '{1, 8'd0,  OP_SUB, 0, 8'd247, 247, 3, 0, 1, 0, 9};
        vecs[10] = '{2, 8'd0,  OP_ADD, 0, 8'd0,   0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 8'd1,  OP_ADD, 0, 8'd0,   1, 1, 0, 0, 0, 0};
        vecs[12] = '{0, 8'd2,  OP_ADD, 0, 8'd0,   2, 2, 0, 0, 0, 0};
        vecs[13] = '{0, 8'd3,  OP_ADD, 0, 8'd0,   3, 3, 0, 0, 0, 0};
        vecs[14] = '{0, 8'd4,  OP_ADD, 0, 8'd0,   4, 4, 0, 0, 0, 0};
        vecs[15] = '{0, 8'd5,  OP_ADD, 0, 8'd0,   4, 4, 1, 0, 0, 0};
        vecs[16] = '{1, 8'd0,  OP_MUL, 0, 8'd12,  12, 3, 0, 1, 3, 4};

        ula_if.ula_done      = 1'b0;
        ula_if.ula_erro      = 1'b0;
        ula_if.ula_resultado = '0;

        repeat (2) @(negedge clk);
        check("rst topo", topo, 0);
        check("rst prof", profundidade, 0);
        check("rst ocupado", ocupado, 0);
        check("rst erro", erro, 0);
        check("rst start", ula_if.ula_start, 0);
        check("rst op", ula_if.ula_op, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            v = vecs[i];
            if (v.cmd == 1) begin
                sel_op         = v.op;
                executar_pulso = 1'b1;
                run_exec(v.mode, v.res, starts, cycles, a_seen, b_seen, op_seen);
                check($sformatf("v%0d starts", i), starts, v.exp_starts);
                if (v.exp_starts == 1) begin
                    check($sformatf("v%0d ula_a", i), a_seen, v.exp_a);
                    check($sformatf("v%0d ula_b", i), b_seen, v.exp_b);
                    check($sformatf("v%0d ula_op", i), op_seen, int'(v.op));
                    check($sformatf("v%0d busy", i), cycles, 2);
                end
            end else begin
                pulse(v.cmd, v.dado);
            end
            check($sformatf("v%0d topo", i), topo, v.exp_topo);
            check($sformatf("v%0d prof", i), profundidade, v.exp_prof);
            check($sformatf("v%0d erro", i), erro, v.exp_erro);
            check($sformatf("v%0d ocupado", i), ocupado, 0);
        end

        // Silent ALU: 1 DISPARA + 15 ESPERA cycles, then fault; late done ignored.
        sel_op = OP_ADD;
        executar_pulso = 1'b1;
        run_exec(2, 8'd0, starts, cycles, a_seen, b_seen, op_seen);
        check("tmo starts", starts, 1);
        check("tmo busy", cycles, 16);
        check("tmo erro", erro, 3);
        check("tmo topo", topo, 12);
        check("tmo prof", profundidade, 3);
        ula_if.ula_done = 1'b1;
        ula_if.ula_resultado = 8'd99;
        @(negedge clk);
        ula_if.ula_done = 1'b0;
        @(negedge clk);
        check("late topo", topo, 12);
        check("late prof", profundidade, 3);
        check("late erro", erro, 3);

        // limpar during ESPERA aborts and empties the stack.
        executar_pulso = 1'b1;
        @(negedge clk);
        executar_pulso = 1'b0;
        check("abort start", ula_if.ula_start, 1);
        @(negedge clk);
        check("abort wait", ocupado, 1);
        limpar_pulso = 1'b1;
        @(negedge clk);
        limpar_pulso = 1'b0;
        check("abort prof", profundidade, 0);
        check("abort topo", topo, 0);
        check("abort ocupado", ocupado, 0);
        check("abort erro", erro, 0);
        ula_if.ula_done = 1'b1;
        ula_if.ula_resultado = 8'd55;
        @(negedge clk);
        ula_if.ula_done = 1'b0;
        check("abort late prof", profundidade, 0);

        // Asynchronous reset while in DISPARA.
        pulse(0, 8'd6);
        pulse(0, 8'd2);
        check("pre-rst prof", profundidade, 2);
        sel_op = OP_SUB;
        executar_pulso = 1'b1;
        @(negedge clk);
        executar_pulso = 1'b0;
        check("pre-rst op", ula_if.ula_op, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid-rst prof", profundidade, 0);
        check("mid-rst topo", topo, 0);
        check("mid-rst ocupado", ocupado, 0);
        check("mid-rst start", ula_if.ula_start, 0);
        check("mid-rst op", ula_if.ula_op, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-rst ocupado", ocupado, 0);
        check("post-rst prof", profundidade, 0);

        // enter and executar together: only executar takes effect.
        pulse(0, 8'd10);
        pulse(0, 8'd4);
        enter_pulso    = 1'b1;
        dados_entrada  = 8'd77;
        executar_pulso = 1'b1;
        sel_op         = OP_ADD;
        run_exec(0, 8'd14, starts, cycles, a_seen, b_seen, op_seen);
        check("prio starts", starts, 1);
        check("prio ula_a", a_seen, 10);
        check("prio ula_b", b_seen, 4);
        check("prio topo", topo, 14);
        check("prio prof", profundidade, 1);
        check("prio erro", erro, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
